// File: rtl/lcd_scan_pkg.sv
// Shared sizes, state encoding and FIFO word layout for the LCD frame-scan sequencer.
package lcd_scan_pkg;
  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;
  localparam int X_W       = 8;
  localparam int Y_W       = 9;
  localparam int PIX_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] pix;
  } fifo_word_t;
endpackage

// File: rtl/lcd_scan_fifo.sv
// Small synchronous FIFO with count/full/empty; head word is read straight from the register array.
module lcd_scan_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 17
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/lcd_frame_scan_ctrl.sv
// Frame-scan sequencer: walks x/y, tracks fixed-latency ROM reads, buffers pixels for a ready/valid writer.
// Optional LCD_SCAN_AUTO_REFRESH_EN: restart the next frame straight from DONE, busy held high.
module lcd_frame_scan_ctrl
  import lcd_scan_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ROM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [X_W-1:0]   xAddLCD,
  output logic [Y_W-1:0]   yAddLCD,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;
  localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

  scan_state_t                  r_state;
  logic [ROM_LAT-1:0]           r_vld_pipe;
  logic [ROM_LAT-1:0]           r_last_pipe;
  logic [CW-1:0]                r_inflight;
  logic [$clog2(FIFO_DEPTH):0]  w_fifo_count;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_issue;
  logic                         w_tap;
  logic                         w_pop;
  logic                         w_at_end;
  fifo_word_t                   w_head;
  fifo_word_t                   w_wdata;

  // Credit covers both buffered pixels and reads still in the ROM pipe, so a tap always finds room.
  assign w_at_end  = (xAddLCD == X_MAX) && (yAddLCD == Y_MAX);
  assign w_issue   = (r_state == SCAN) && !w_full &&
                     ((CW'(w_fifo_count) + r_inflight) < CW'(FIFO_DEPTH));
  assign w_tap     = r_vld_pipe[ROM_LAT-1];
  assign pix_valid = ~w_empty;
  assign pix_out   = w_head.pix;
  assign pix_last  = w_head.last & pix_valid;
  assign w_pop     = pix_valid & pix_ready;
  assign w_wdata   = '{last: r_last_pipe[ROM_LAT-1], pix: pix_in};

  lcd_scan_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fifo_word_t))
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_tap),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_inflight  <= '0;
    end else begin
      r_vld_pipe[0]  <= w_issue;
      r_last_pipe[0] <= w_issue & w_at_end;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      case ({w_issue, w_tap})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      xAddLCD <= '0;
      yAddLCD <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= SCAN;
            busy    <= 1'b1;
            xAddLCD <= '0;
            yAddLCD <= '0;
          end
        end
        SCAN: begin
          if (w_issue) begin
            if (w_at_end) begin
              r_state <= DRAIN;
            end else if (xAddLCD == X_MAX) begin
              xAddLCD <= '0;
              yAddLCD <= yAddLCD + 1'b1;
            end else begin
              xAddLCD <= xAddLCD + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The flagged pixel is the final push, so its handshake means pipe and FIFO are empty.
          if (w_pop && pix_last && (r_inflight == '0)) begin
            r_state <= DONE;
            done    <= 1'b1;
`ifndef LCD_SCAN_AUTO_REFRESH_EN
            busy    <= 1'b0;
`endif
          end
        end
        DONE: begin
`ifdef LCD_SCAN_AUTO_REFRESH_EN
          r_state <= SCAN;
`else
          r_state <= IDLE;
`endif
          xAddLCD <= '0;
          yAddLCD <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_frame_scan_ctrl.sv
// Directed bench for lcd_frame_scan_ctrl: a 4x3 instance for most scenarios plus a default-size instance.
module tb_lcd_frame_scan_ctrl;
  logic        clock = 1'b0;
  logic        reset, start, pix_ready;
  logic        busy, done, pix_valid, pix_last;
  logic [7:0]  xAddLCD;
  logic [8:0]  yAddLCD;
  logic [15:0] pix_in, pix_out;

  logic        start_b, pix_ready_b;
  logic        busy_b, done_b, pix_valid_b, pix_last_b;
  logic [7:0]  xb;
  logic [8:0]  yb;
  logic [15:0] pix_in_b, pix_out_b;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  lcd_frame_scan_ctrl #(.H_RES(4), .V_RES(3), .ROM_LAT(2), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .xAddLCD(xAddLCD), .yAddLCD(yAddLCD), .pix_in(pix_in), .pix_out(pix_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last));

  lcd_frame_scan_ctrl dut_big (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .xAddLCD(xb), .yAddLCD(yb), .pix_in(pix_in_b), .pix_out(pix_out_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .pix_last(pix_last_b));

  function automatic logic [15:0] gen_pix(input logic [7:0] x, input logic [8:0] y);
    return {y[7:0], x} ^ 16'h5A00;
  endfunction

  // Image generator model: two-cycle registered ROM.
  logic [7:0] rx1 = '0, rx2 = '0, bx1 = '0, bx2 = '0;
  logic [8:0] ry1 = '0, ry2 = '0, by1 = '0, by2 = '0;
  always @(posedge clock) begin
    rx1 <= xAddLCD; ry1 <= yAddLCD; rx2 <= rx1; ry2 <= ry1;
    bx1 <= xb;      by1 <= yb;      bx2 <= bx1; by2 <= by1;
  end
  assign pix_in   = gen_pix(rx2, ry2);
  assign pix_in_b = gen_pix(bx2, by2);

  int          t_now = 0;
  int          n_done, t_done, max_credit;
  logic        done_busy, busy_prev_at_done, prev_busy;
  logic [15:0] q_pix[$];
  logic        q_last[$];
  int          q_t[$];

  task automatic clear_rec();
    q_pix.delete(); q_last.delete(); q_t.delete();
    n_done = 0; t_done = -1; max_credit = 0;
    done_busy = 1'bx; busy_prev_at_done = 1'bx; prev_busy = busy;
  endtask

  // One clock: drive at negedge, record what the following posedge will see.
  task automatic step(input logic rdy, input logic st);
    int cr;
    @(negedge clock);
    pix_ready = rdy;
    start     = st;
    t_now++;
    if (pix_valid && pix_ready) begin
      q_pix.push_back(pix_out); q_last.push_back(pix_last); q_t.push_back(t_now);
    end
    if (done) begin
      n_done++; t_done = t_now; done_busy = busy; busy_prev_at_done = prev_busy;
    end
    cr = int'(dut.w_fifo_count) + int'(dut.r_inflight);
    if (cr > max_credit) max_credit = cr;
    prev_busy = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; pix_ready = 1'b0; start_b = 1'b0; pix_ready_b = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", pix_valid); end
    checks++; if (pix_last !== 1'b0)  begin errors++; $display("FAIL rst_last got %b want 0", pix_last); end
    checks++; if (pix_out !== 16'h0)  begin errors++; $display("FAIL rst_pix got %h want 0", pix_out); end
    checks++; if ({xAddLCD, yAddLCD} !== 17'h0) begin errors++; $display("FAIL rst_addr got %0d,%0d want 0,0", xAddLCD, yAddLCD); end
    reset = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_frame_ready1();
    int ts;
    clear_rec();
    step(1'b1, 1'b1); ts = t_now;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0);
      checks++; if (pix_valid !== (k == 4)) begin errors++; $display("FAIL first_valid step %0d got %b want %b", k, pix_valid, k == 4); end
      if (k == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_on got %b want 1", busy); end
      end
    end
    for (int k = 0; k < 40 && n_done == 0; k++) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    checks++; if (n_done !== 1)            begin errors++; $display("FAIL r1_done_cnt got %0d want 1", n_done); end
    checks++; if (t_done !== ts + 16)      begin errors++; $display("FAIL r1_done_time got %0d want %0d", t_done - ts, 16); end
    checks++; if (done_busy !== 1'b0 || busy_prev_at_done !== 1'b1) begin errors++; $display("FAIL r1_busy_fall got %b%b want 10", busy_prev_at_done, done_busy); end
    checks++; if (q_pix.size() !== 12)     begin errors++; $display("FAIL r1_count got %0d want 12", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 12; i++) begin
      checks++; if (q_pix[i] !== gen_pix(8'(i % 4), 9'(i / 4))) begin errors++; $display("FAIL r1_pix[%0d] got %h want %h", i, q_pix[i], gen_pix(8'(i % 4), 9'(i / 4))); end
      checks++; if (q_last[i] !== (i == 11)) begin errors++; $display("FAIL r1_last[%0d] got %b want %b", i, q_last[i], i == 11); end
      checks++; if (q_t[i] !== ts + 4 + i)   begin errors++; $display("FAIL r1_rate[%0d] got %0d want %0d", i, q_t[i] - ts, 4 + i); end
    end
    checks++; if ({xAddLCD, yAddLCD} !== 17'h0 || busy !== 1'b0) begin errors++; $display("FAIL r1_idle got x=%0d y=%0d busy=%b want 0,0,0", xAddLCD, yAddLCD, busy); end
  endtask

  task automatic test_backpressure();
    int low;
    clear_rec();
    low = 0;
    step(1'b1, 1'b1);
    for (int k = 0; k < 200 && n_done == 0; k++) begin
      if (q_pix.size() >= 3 && low < 20) begin
        step(1'b0, 1'b0); low++;
        if (low == 10 || low == 20) begin
          checks++; if (xAddLCD !== 8'd3 || yAddLCD !== 9'd1) begin errors++; $display("FAIL bp_hold@%0d got %0d,%0d want 3,1", low, xAddLCD, yAddLCD); end
        end
      end else begin
        step(1'b1, 1'b0);
      end
    end
    checks++; if (max_credit > 4)      begin errors++; $display("FAIL bp_credit got %0d want <=4", max_credit); end
    checks++; if (n_done !== 1)        begin errors++; $display("FAIL bp_done got %0d want 1", n_done); end
    checks++; if (q_pix.size() !== 12) begin errors++; $display("FAIL bp_count got %0d want 12", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 12; i++) begin
      checks++; if (q_pix[i] !== gen_pix(8'(i % 4), 9'(i / 4)) || q_last[i] !== (i == 11)) begin errors++; $display("FAIL bp_pix[%0d] got %h/%b want %h/%b", i, q_pix[i], q_last[i], gen_pix(8'(i % 4), 9'(i / 4)), i == 11); end
    end
  endtask

  task automatic test_random_ready();
    clear_rec();
    step(1'b1, 1'b1);
    for (int k = 0; k < 300 && n_done == 0; k++) step(1'($urandom_range(0, 1)), 1'b0);
    checks++; if (n_done !== 1)        begin errors++; $display("FAIL rnd_done got %0d want 1", n_done); end
    checks++; if (q_pix.size() !== 12) begin errors++; $display("FAIL rnd_count got %0d want 12", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 12; i++) begin
      checks++; if (q_pix[i] !== gen_pix(8'(i % 4), 9'(i / 4)) || q_last[i] !== (i == 11)) begin errors++; $display("FAIL rnd_pix[%0d] got %h/%b want %h/%b", i, q_pix[i], q_last[i], gen_pix(8'(i % 4), 9'(i / 4)), i == 11); end
    end
  endtask

  task automatic test_start_ignored();
    int  ts;
    logic pulsed;
    clear_rec();
    pulsed = 1'b0;
    step(1'b1, 1'b1); ts = t_now;
    for (int k = 0; k < 40 && n_done == 0; k++) begin
      if (q_pix.size() == 5 && !pulsed) begin step(1'b1, 1'b1); pulsed = 1'b1; end
      else step(1'b1, 1'b0);
    end
    repeat (30) step(1'b1, 1'b0);
    checks++; if (n_done !== 1)        begin errors++; $display("FAIL st_done got %0d want 1", n_done); end
    checks++; if (t_done !== ts + 16)  begin errors++; $display("FAIL st_done_time got %0d want 16", t_done - ts); end
    checks++; if (q_pix.size() !== 12) begin errors++; $display("FAIL st_count got %0d want 12", q_pix.size()); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL st_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    clear_rec();
    step(1'b1, 1'b1);
    for (int k = 0; k < 40 && q_pix.size() < 7; k++) step(1'b1, 1'b0);
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b want 1", pix_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy, done, pix_valid, pix_last} !== 4'b0) begin errors++; $display("FAIL rm_flags got %b want 0000", {busy, done, pix_valid, pix_last}); end
    checks++; if (pix_out !== 16'h0) begin errors++; $display("FAIL rm_pix got %h want 0", pix_out); end
    checks++; if ({xAddLCD, yAddLCD} !== 17'h0) begin errors++; $display("FAIL rm_addr got %0d,%0d want 0,0", xAddLCD, yAddLCD); end
    checks++; if (int'(dut.w_fifo_count) + int'(dut.r_inflight) !== 0) begin errors++; $display("FAIL rm_flush got %0d want 0", int'(dut.w_fifo_count) + int'(dut.r_inflight)); end
    @(negedge clock) reset = 1'b0;
    clear_rec();
    repeat (5) step(1'b1, 1'b0);
    checks++; if (n_done !== 0) begin errors++; $display("FAIL rm_no_done got %0d want 0", n_done); end
    step(1'b1, 1'b1);
    for (int k = 0; k < 40 && n_done == 0; k++) step(1'b1, 1'b0);
    checks++; if (n_done !== 1 || q_pix.size() !== 12) begin errors++; $display("FAIL rm_replay got done=%0d n=%0d want 1,12", n_done, q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 12; i++) begin
      checks++; if (q_pix[i] !== gen_pix(8'(i % 4), 9'(i / 4))) begin errors++; $display("FAIL rm_pix[%0d] got %h want %h", i, q_pix[i], gen_pix(8'(i % 4), 9'(i / 4))); end
    end
  endtask

  task automatic test_default_frame();
    int first_v, hs, mism, bad_last, n_d;
    logic seen_done;
    first_v = -1; hs = 0; mism = 0; bad_last = 0; n_d = 0; seen_done = 1'b0;
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    for (int k = 1; k <= 77000 && !seen_done; k++) begin
      if (k > 1) @(negedge clock);
      if (first_v < 0 && pix_valid_b) first_v = k;
      if (pix_valid_b && pix_ready_b) begin
        if (pix_out_b !== gen_pix(8'(hs % 240), 9'(hs / 240))) mism++;
        if (pix_last_b !== (hs == 76799)) bad_last++;
        hs++;
      end
      if (done_b) begin n_d++; seen_done = 1'b1; end
    end
    repeat (4) begin @(negedge clock); if (done_b) n_d++; end
    checks++; if (first_v !== 4)   begin errors++; $display("FAIL big_first_valid got %0d want 4", first_v - 1); end
    checks++; if (hs !== 76800)    begin errors++; $display("FAIL big_handshakes got %0d want 76800", hs); end
    checks++; if (mism !== 0)      begin errors++; $display("FAIL big_pix_errs got %0d want 0", mism); end
    checks++; if (bad_last !== 0)  begin errors++; $display("FAIL big_last_errs got %0d want 0", bad_last); end
    checks++; if (n_d !== 1)       begin errors++; $display("FAIL big_done got %0d want 1", n_d); end
  endtask

`ifdef LCD_SCAN_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int ts, gaps;
    clear_rec();
    gaps = 0;
    step(1'b1, 1'b1); ts = t_now;
    for (int k = 0; k < 120 && n_done < 2; k++) begin
      step(1'b1, 1'b0);
      if (!busy) gaps++;
    end
    checks++; if (n_done !== 2)        begin errors++; $display("FAIL ar_done got %0d want 2", n_done); end
    checks++; if (t_done !== ts + 32)  begin errors++; $display("FAIL ar_done_time got %0d want 32", t_done - ts); end
    checks++; if (gaps !== 0)          begin errors++; $display("FAIL ar_busy_gaps got %0d want 0", gaps); end
    checks++; if (q_pix.size() < 24)   begin errors++; $display("FAIL ar_count got %0d want >=24", q_pix.size()); end
    for (int i = 0; i < q_pix.size() && i < 24; i++) begin
      checks++; if (q_pix[i] !== gen_pix(8'(i % 4), 9'((i % 12) / 4)) || q_last[i] !== (i % 12 == 11)) begin errors++; $display("FAIL ar_pix[%0d] got %h/%b want %h/%b", i, q_pix[i], q_last[i], gen_pix(8'(i % 4), 9'((i % 12) / 4)), i % 12 == 11); end
    end
    if (q_t.size() > 12) begin
      checks++; if (q_t[12] !== ts + 20) begin errors++; $display("FAIL ar_restart got %0d want 20", q_t[12] - ts); end
    end
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
`ifdef LCD_SCAN_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_frame_ready1();
    test_backpressure();
    test_random_ready();
    test_start_ignored();
    test_reset_mid();
    test_default_frame();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lcd_frame_scan_ctrl.md
Name: lcd_frame_scan_ctrl

Overview:
- Frame-scan sequencer for the LCD image path.
- Walks the LCD x/y address space that drives the face image generator, and absorbs the generator's fixed ROM read latency.
- Delivers pixels to the LCD write interface over a ready/valid handshake with full backpressure.
- Sits between the top-level screen logic (start/done) and the LCD pixel writer.

Parameters:
- H_RES, 240, pixels per line; x range 0..H_RES-1.
- V_RES, 320, lines per frame; y range 0..V_RES-1.
- ROM_LAT, 2, clock cycles from address presented to pix_in valid (fixed, ≥1).
- FIFO_DEPTH, 4, output buffer entries; power of 2, ≥ ROM_LAT+1.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame scan when idle.
- busy  output  1  high from accepted start until the last pixel handshakes.
- done  output  1  one-cycle pulse after the last pixel handshake.
- xAddLCD  output  8  x address to the image generator.
- yAddLCD  output  9  y address to the image generator.
- pix_in  input  16  RGB565 pixel from the generator, ROM_LAT cycles after its address.
- pix_out  output  16  pixel to the LCD writer.
- pix_valid  output  1  pix_out holds a valid pixel.
- pix_ready  input  1  LCD writer accepts pix_out this cycle.
- pix_last  output  1  qualifies pix_out as pixel (H_RES-1, V_RES-1).

Behaviour:
- Reset values (async, immediate):
  - busy=0, done=0, pix_valid=0, pix_last=0, pix_out=0.
  - xAddLCD=0, yAddLCD=0.
  - FIFO empty, in-flight count 0, FSM=IDLE.
- FSM states:
  - IDLE: wait for start. start=1 → SCAN, busy=1, counters at (0,0).
  - SCAN: issue one address per cycle while credit is available. The issue after (H_RES-1, V_RES-1) → DRAIN.
  - DRAIN: no new issues. Wait until in-flight=0, FIFO empty and last handshake done → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Scan order: x fastest. x wraps H_RES-1→0 and increments y. Total H_RES*V_RES pixels (76800 default).
- Credit rule: issue only when (fifo_count + inflight) < FIFO_DEPTH. Otherwise hold xAddLCD/yAddLCD unchanged; the address counter does not advance.
- Issue tracking:
  - A ROM_LAT-deep shift register carries an issue-valid bit and a last-flag per issued address.
  - When the tap emerges, pix_in and the last-flag are written to the FIFO.
  - Writes are never dropped; the credit rule guarantees space.
- Output:
  - pix_valid = FIFO non-empty; pix_out and pix_last come from the FIFO head.
  - Pop on pix_valid & pix_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - With pix_ready held high, steady-state throughput is 1 pixel/clock.
  - First pix_valid appears ROM_LAT+1 cycles after start (registered FIFO output).
- inflight accounting: +1 per issue, −1 per tap emergence; simultaneous issue and emergence leave it unchanged.
- start while busy is ignored; no restart and no queuing.
- pix_ready is ignored when pix_valid=0.
- Address ports are registered and stay at the last issued address in DRAIN/DONE. They return to (0,0) on entry to IDLE.
- Reset mid-frame:
  - Immediate return to IDLE.
  - In-flight and FIFO contents discarded; no done pulse.
- Widths:
  - x counter 8 bits, y counter 9 bits.
  - Compare against H_RES-1 and V_RES-1 at full width; no implicit wrap at 256/512.

Optional Feature:
- Macro: LCD_SCAN_AUTO_REFRESH_EN.
- Defined:
  - DONE → SCAN directly, counters at (0,0); done still pulses once per frame.
  - busy stays high continuously.
  - start is only needed for the first frame.
- Undefined:
  - DONE → IDLE; each frame requires a new start pulse.

Decomposition:
- Package lcd_scan_pkg holds:
  - default H_RES/V_RES;
  - X_W=8, Y_W=9, PIX_W=16;
  - state encoding (IDLE, SCAN, DRAIN, DONE).
- One sub-module, lcd_scan_fifo:
  - synchronous FIFO, FIFO_DEPTH × (PIX_W+1);
  - count, full and empty outputs;
  - async active-high reset.

Test Plan:
- Reset, then start with pix_ready=1, H_RES=4, V_RES=3, ROM_LAT=2:
  - 12 pixels emitted in order (0,0)…(3,2), one per clock;
  - pix_last only on the 12th;
  - done pulses once, busy falls the same cycle.
- Default sizes, pix_ready=1 throughout: exactly 76800 handshakes, first pix_valid 3 cycles after start.
- pix_ready held low 20 cycles mid-frame:
  - fifo_count+inflight never exceeds 4;
  - address holds;
  - no pixel lost or duplicated; the model compares pix_out against a generator model.
- pix_ready random 50% toggle over a full 4×3 frame: pixel sequence and pix_last identical to the ready=1 run.
- start pulsed again at pixel 5 while busy: ignored; a single frame with a single done.
- reset asserted at pixel 7 with FIFO non-empty:
  - outputs return to reset values immediately;
  - a new start replays from (0,0).
- With LCD_SCAN_AUTO_REFRESH_EN: two back-to-back frames, done pulses twice, no idle gap beyond the DONE cycle.
